bus_sequencer: RTL and testbench

BUS_SEQUENCER -- requirements
Module: bus_sequencer

---
 rtl/bus_sequencer.sv | 148 ++++++++++++++
 tb/tb_bus_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_sequencer.sv
// Bus move sequencer: copies one register's held value to another register over a shared bus.
// Optional external-source moves are enabled by defining BUS_SEQ_EXT_SRC_EN.
module bus_sequencer #(
  parameter int unsigned NREG = 4,
  parameter int unsigned W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_src,
  input  logic [2:0]        req_dst,
  input  logic              req_ext,
  input  logic [W-1:0]      ext_data,
  input  logic [NREG*W-1:0] reg_out,
  output logic [NREG-1:0]   bw_en,
  output logic [NREG-1:0]   br_en,
  output logic [W-1:0]      bus,
  output logic              done,
  output logic              err
);

  localparam logic [3:0] NREG_L = 4'(NREG);

  typedef enum logic [2:0] {IDLE, DRIVE, CAPTURE, FINISH, ERROR} state_t;

  state_t          state_q, state_d;
  logic [2:0]      src_q, src_d;
  logic [2:0]      dst_q, dst_d;
  logic [NREG-1:0] bw_en_q, bw_en_d;
  logic [NREG-1:0] br_en_q, br_en_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            req_ext_eff;
  logic            dst_bad, src_bad, reject;
  logic [W-1:0]    src_val;

`ifdef BUS_SEQ_EXT_SRC_EN
  logic            ext_q, ext_d;
  logic [W-1:0]    data_q, data_d;
  assign req_ext_eff = req_ext;
`else
  logic            unused_ext;
  assign req_ext_eff = 1'b0;
  assign unused_ext  = ^{req_ext, ext_data};
`endif

  assign dst_bad = ({1'b0, req_dst} >= NREG_L);
  assign src_bad = ({1'b0, req_src} >= NREG_L) || (req_src == req_dst);
  assign reject  = dst_bad || (!req_ext_eff && src_bad);

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    bw_en_d = '0;
    br_en_d = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef BUS_SEQ_EXT_SRC_EN
    ext_d   = ext_q;
    data_d  = data_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          src_d = req_src;
          dst_d = req_dst;
`ifdef BUS_SEQ_EXT_SRC_EN
          ext_d  = req_ext;
          data_d = ext_data;
`endif
          // Enables are registered, so the first enable is decoded from the raw request here.
          if (reject) begin
            state_d = ERROR;
            err_d   = 1'b1;
          end else if (req_ext_eff) begin
            state_d = CAPTURE;
            for (int unsigned i = 0; i < NREG; i++) br_en_d[i] = (req_dst == 3'(i));
          end else begin
            state_d = DRIVE;
            for (int unsigned i = 0; i < NREG; i++) bw_en_d[i] = (req_src == 3'(i));
          end
        end
      end
      DRIVE: begin
        state_d = CAPTURE;
        for (int unsigned i = 0; i < NREG; i++) br_en_d[i] = (dst_q == 3'(i));
      end
      CAPTURE: begin
        state_d = FINISH;
        done_d  = 1'b1;
      end
      FINISH:  state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    src_val = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (src_q == 3'(i)) src_val = reg_out[i*W +: W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      bw_en_q <= '0;
      br_en_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef BUS_SEQ_EXT_SRC_EN
      ext_q   <= 1'b0;
      data_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      bw_en_q <= bw_en_d;
      br_en_q <= br_en_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef BUS_SEQ_EXT_SRC_EN
      ext_q   <= ext_d;
      data_q  <= data_d;
`endif
    end
  end

  // Bus follows reg_out live in CAPTURE: the source register only updates at the end of DRIVE.
`ifdef BUS_SEQ_EXT_SRC_EN
  assign bus = (state_q == CAPTURE) ? (ext_q ? data_q : src_val) : '0;
`else
  assign bus = (state_q == CAPTURE) ? src_val : '0;
`endif

  assign req_ready = rst_n && (state_q == IDLE);
  assign bw_en     = bw_en_q;
  assign br_en     = br_en_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bus_sequencer.sv
// Bench for bus_sequencer: directed cases then random moves against a move-level reference model,
// with a small register-file environment answering bw_en/br_en.
module tb_bus_sequencer;
  localparam int unsigned NREG = 4;
  localparam int unsigned W    = 8;
`ifdef BUS_SEQ_EXT_SRC_EN
  localparam bit EXT_EN = 1'b1;
`else
  localparam bit EXT_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_src, req_dst;
  logic              req_ext;
  logic [W-1:0]      ext_data;
  logic [NREG*W-1:0] reg_out;
  logic [NREG-1:0]   bw_en, br_en;
  logic [W-1:0]      bus;
  logic              done, err;

  bus_sequencer #(.NREG(NREG), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_dst(req_dst), .req_ext(req_ext), .ext_data(ext_data),
    .reg_out(reg_out), .bw_en(bw_en), .br_en(br_en), .bus(bus), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Register file environment: out <= hold on bw_en, hold <= bus on br_en.
  logic [W-1:0] env_hold [NREG];
  logic [W-1:0] env_out  [NREG];
  logic         ld_en = 1'b0;
  logic [1:0]   ld_idx = '0;
  logic [W-1:0] ld_val = '0;

  always @(posedge clk) begin
    if (ld_en) env_hold[ld_idx] <= ld_val;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (bw_en[i]) env_out[i]  <= env_hold[i];
      if (br_en[i]) env_hold[i] <= bus;
    end
  end

  always_comb begin
    reg_out = '0;
    for (int unsigned i = 0; i < NREG; i++) reg_out[i*W +: W] = env_out[i];
  end

  // Reference: expected held value of every register after each completed move.
  logic [W-1:0] mdl_hold [NREG];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    n_cmp++;
    assert ($countones({bw_en, br_en}) <= 1) else begin
      n_bad++;
      $error("FAIL onehot: observed bw_en=%b br_en=%b expected at most one bit", bw_en, br_en);
    end
  end

  task automatic check_outs(input string ph, input logic [NREG-1:0] eb, input logic [NREG-1:0] er,
                            input logic [W-1:0] ebus, input logic ed, input logic ee, input logic erdy);
    check({ph, ".bw_en"},     32'(bw_en),     32'(eb));
    check({ph, ".br_en"},     32'(br_en),     32'(er));
    check({ph, ".bus"},       32'(bus),       32'(ebus));
    check({ph, ".done"},      32'(done),      32'(ed));
    check({ph, ".err"},       32'(err),       32'(ee));
    check({ph, ".req_ready"}, 32'(req_ready), 32'(erdy));
  endtask

  task automatic load_reg(input int unsigned idx, input logic [W-1:0] val);
    ld_en  = 1'b1;
    ld_idx = 2'(idx);
    ld_val = val;
    @(negedge clk);
    ld_en = 1'b0;
    mdl_hold[idx] = val;
  endtask

  // Called at a negedge with the sequencer idle; returns at the negedge where it is idle again.
  task automatic run_req(input int unsigned s, input int unsigned d, input logic e,
                         input logic [W-1:0] x, input bit keep_valid);
    bit              e_eff, bad;
    int unsigned     ncyc, step;
    logic [W-1:0]    val;
    logic [NREG-1:0] eb, er;
    logic [W-1:0]    ebus;
    e_eff = EXT_EN ? e : 1'b0;
    bad   = (d >= NREG) || (!e_eff && ((s >= NREG) || (s == d)));
    val   = '0;
    if (!bad) val = e_eff ? x : mdl_hold[s];
    ncyc  = bad ? 1 : (e_eff ? 2 : 3);
    check_outs("idle", '0, '0, '0, 1'b0, 1'b0, 1'b1);
    req_valid = 1'b1;
    req_src   = 3'(s);
    req_dst   = 3'(d);
    req_ext   = e;
    ext_data  = x;
    for (int unsigned c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (keep_valid) begin
        req_src  = 3'($urandom);
        req_dst  = 3'($urandom);
        req_ext  = 1'($urandom);
        ext_data = W'($urandom);
      end else begin
        req_valid = 1'b0;
      end
      eb = '0; er = '0; ebus = '0;
      if (bad) begin
        check_outs("reject", '0, '0, '0, 1'b0, 1'b1, 1'b0);
      end else begin
        // step 1 = source drives, 2 = destination captures, 3 = completion pulse
        step = e_eff ? c + 1 : c;
        if (step == 1) begin
          eb[s] = 1'b1;
          check_outs("drive", eb, er, ebus, 1'b0, 1'b0, 1'b0);
        end else if (step == 2) begin
          er[d] = 1'b1;
          check_outs("capture", eb, er, val, 1'b0, 1'b0, 1'b0);
        end else begin
          check_outs("finish", '0, '0, '0, 1'b1, 1'b0, 1'b0);
        end
      end
    end
    if (!bad) mdl_hold[d] = val;
    @(negedge clk);
  endtask

  task automatic reset_mid_capture();
    logic [NREG-1:0] eb, er;
    check_outs("rst.idle", '0, '0, '0, 1'b0, 1'b0, 1'b1);
    req_valid = 1'b1; req_src = 3'd2; req_dst = 3'd0; req_ext = 1'b0; ext_data = 8'h00;
    @(negedge clk);
    req_valid = 1'b0;
    eb = '0; eb[2] = 1'b1;
    check_outs("rst.drive", eb, '0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    er = '0; er[0] = 1'b1;
    check_outs("rst.capture", '0, er, mdl_hold[2], 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_outs("rst.async", '0, '0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_outs("rst.held", '0, '0, '0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1 check_outs("rst.release", '0, '0, '0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check_outs("rst.nodone", '0, '0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    bit prev_keep;
    bit keep;
    rst_n = 1'b0; req_valid = 1'b0; req_src = '0; req_dst = '0; req_ext = 1'b0; ext_data = '0;
    for (int unsigned i = 0; i < NREG; i++) env_out[i] = '0;
    #3 check_outs("reset", '0, '0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("reset.ready_rise", 32'(req_ready), 32'd1);
    for (int unsigned i = 0; i < NREG; i++) load_reg(i, W'($urandom));
    load_reg(1, 8'h5A);

    run_req(1, 3, 1'b0, 8'h00, 1'b0);   // reg 1 (0x5A) -> reg 3
    run_req(2, 2, 1'b0, 8'h00, 1'b0);   // src == dst
    run_req(1, 5, 1'b0, 8'h00, 1'b0);   // dst out of range
    run_req(1, 0, 1'b1, 8'hC3, 1'b0);   // external source (register move when disabled)
    run_req(4, 1, 1'b1, 8'h3C, 1'b0);   // src out of range, rejected only without ext support
    run_req(0, 2, 1'b0, 8'h00, 1'b1);   // back-to-back with req_valid held
    run_req(3, 1, 1'b0, 8'h00, 1'b0);
    reset_mid_capture();
    run_req(2, 1, 1'b0, 8'h00, 1'b0);

    prev_keep = 1'b0;
    for (int unsigned n = 0; n < 60; n++) begin
      if (!prev_keep && $urandom_range(0, 3) == 0) load_reg($urandom_range(0, NREG-1), W'($urandom));
      keep = (n != 59) && ($urandom_range(0, 2) == 0);
      run_req($urandom_range(0, 3) == 0 ? $urandom_range(0, 7) : $urandom_range(0, NREG-1),
              $urandom_range(0, 5) == 0 ? $urandom_range(0, 7) : $urandom_range(0, NREG-1),
              1'($urandom), W'($urandom), keep);
      prev_keep = keep;
    end

    for (int unsigned i = 0; i < NREG; i++) check("final.hold", 32'(env_hold[i]), 32'(mdl_hold[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
